// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the codec transmit and receive slaves.
// Sample width, slot FSM states and lrck edge-detect encodings.
package i2s_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } state_e;

  // Edge codes as {lrck delayed, lrck now}
  localparam logic [1:0] LRCK_FALL = 2'b10;
  localparam logic [1:0] LRCK_RISE = 2'b01;

endpackage

// File: rtl/i2s_tx_shifter.sv
// MSB-first slot serialiser for the I2S transmit slave.
// A load drives the MSB at once; remaining bits follow, then zeros.
module i2s_tx_shifter
  import i2s_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  output logic              sdata
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sdata_q, sdata_d;

  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    sdata_d = 1'b0;
    if (load) begin
      sdata_d = word[DATA_W-1];
      sh_d    = {word[DATA_W-2:0], 1'b0};
      cnt_d   = CW'(DATA_W - 1);
    end else if (cnt_q != '0) begin
      sdata_d = sh_q[DATA_W-1];
      sh_d    = {sh_q[DATA_W-2:0], 1'b0};
      cnt_d   = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      sdata_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      sdata_q <= sdata_d;
    end
  end

  assign sdata = sdata_q;

endmodule

// File: rtl/i2s_tx_slave.sv
// I2S transmit slave: bclk/lrck from the codec, one-frame holding
// register toward the producer, underrun pulse on empty frame start.
module i2s_tx_slave
  import i2s_pkg::*;
#(
  parameter int DATA_W        = SAMPLE_W,
  parameter bit UNDERRUN_ZERO = 1'b1
) (
  input  logic              bclk,
  input  logic              rst,
  input  logic              lrck,
  input  logic [DATA_W-1:0] tx_l_data,
  input  logic [DATA_W-1:0] tx_r_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sdata,
  output logic              underrun
);

  logic              lrck_q;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] hold_r_q, hold_r_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] pend_r_q, pend_r_d;
  logic [DATA_W-1:0] last_l_q, last_l_d;
  logic [DATA_W-1:0] last_r_q, last_r_d;
  logic              underrun_q, underrun_d;

  logic              fall, rise;
  logic              frame_load, right_load;
  logic              accept;
  logic              load;
  logic [DATA_W-1:0] load_word;

  assign fall       = ({lrck_q, lrck} == LRCK_FALL);
  assign rise       = ({lrck_q, lrck} == LRCK_RISE);
  assign frame_load = fall && (state_q != LEFT);
  assign right_load = rise && (state_q == LEFT);
  assign accept     = tx_valid && !hold_full_q;
  assign load       = frame_load || right_load;

  always_comb begin
    state_d     = state_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    pend_r_d    = pend_r_q;
    last_l_d    = last_l_q;
    last_r_d    = last_r_q;
    underrun_d  = 1'b0;
    load_word   = '0;

    case (state_q)
      IDLE:    if (fall) state_d = LEFT;
      LEFT:    if (rise) state_d = RIGHT;
      RIGHT:   if (fall) state_d = LEFT;
      default: state_d = IDLE;
    endcase

    if (frame_load) begin
      hold_full_d = 1'b0;
      if (hold_full_q) begin
        load_word = hold_l_q;
        pend_r_d  = hold_r_q;
        last_l_d  = hold_l_q;
        last_r_d  = hold_r_q;
      end else begin
        underrun_d = 1'b1;
        load_word  = UNDERRUN_ZERO ? '0 : last_l_q;
        pend_r_d   = UNDERRUN_ZERO ? '0 : last_r_q;
      end
    end else if (right_load) begin
      load_word = pend_r_q;
    end

    // Accept wins over the load clear: only possible when empty
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = tx_l_data;
      hold_r_d    = tx_r_data;
    end
  end

  always_ff @(posedge bclk) begin
    lrck_q <= lrck;
    if (rst) begin
      state_q     <= IDLE;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      pend_r_q    <= '0;
      last_l_q    <= '0;
      last_r_q    <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      pend_r_q    <= pend_r_d;
      last_l_q    <= last_l_d;
      last_r_q    <= last_r_d;
      underrun_q  <= underrun_d;
    end
  end

  i2s_tx_shifter #(
    .DATA_W(DATA_W)
  ) u_shifter (
    .clk  (bclk),
    .rst  (rst),
    .load (load),
    .word (load_word),
    .sdata(sdata)
  );

  assign tx_ready = ~hold_full_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_slave.sv
// Scoreboard bench for i2s_tx_slave: zero-fill and repeat instances
// driven in parallel, expected slot bits queued per frame.
module tb_i2s_tx_slave;
  import i2s_pkg::*;

  localparam int W = 16;

  logic         bclk = 1'b0;
  logic         rst = 1'b1;
  logic         lrck = 1'b1;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_l = '0;
  logic [W-1:0] tx_r = '0;
  logic         ready0, sd0, ur0;
  logic         ready1, sd1, ur1;
  logic         rdy_prev = 1'b1;

  typedef struct packed {
    logic sd0;
    logic sd1;
    logic ur;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 bclk = ~bclk;

  i2s_tx_slave #(
    .DATA_W(W),
    .UNDERRUN_ZERO(1'b1)
  ) u_zero (
    .bclk     (bclk),
    .rst      (rst),
    .lrck     (lrck),
    .tx_l_data(tx_l),
    .tx_r_data(tx_r),
    .tx_valid (tx_valid),
    .tx_ready (ready0),
    .sdata    (sd0),
    .underrun (ur0)
  );

  i2s_tx_slave #(
    .DATA_W(W),
    .UNDERRUN_ZERO(1'b0)
  ) u_rep (
    .bclk     (bclk),
    .rst      (rst),
    .lrck     (lrck),
    .tx_l_data(tx_l),
    .tx_r_data(tx_r),
    .tx_valid (tx_valid),
    .tx_ready (ready1),
    .sdata    (sd1),
    .underrun (ur1)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  task automatic edge_drive(input logic lv);
    @(posedge bclk);
    #1;
    if (tx_valid && rdy_prev) tx_valid = 1'b0;
    lrck = lv;
    @(negedge bclk);
    rdy_prev = ready0;
  endtask

  task automatic offer(input logic [W-1:0] l, input logic [W-1:0] r);
    tx_l     = l;
    tx_r     = r;
    tx_valid = 1'b1;
  endtask

  task automatic idle(input string tag, input int n, input logic lv);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      edge_drive(lv);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      n_cmp++;
      if (sd0 !== e.sd0 || sd1 !== e.sd1 || ur0 !== e.ur || ur1 !== e.ur) begin
        n_bad++;
        $display("FAIL %s cyc %0d: got sd=%b/%b ur=%b/%b want sd=%b/%b ur=%b",
                 tag, c, sd0, sd1, ur0, ur1, e.sd0, e.sd1, e.ur);
      end
    end
  endtask

  task automatic send_frame(input string tag, input int s,
                            input logic [W-1:0] l0, input logic [W-1:0] r0,
                            input logic [W-1:0] l1, input logic [W-1:0] r1,
                            input logic ur);
    exp_t e;
    if (exp_q.size() == 0) exp_q.push_back('0);
    for (int i = 0; i < 2 * s; i++) begin
      int j;
      logic [W-1:0] w0, w1;
      j  = (i < s) ? i : i - s;
      w0 = (i < s) ? l0 : r0;
      w1 = (i < s) ? l1 : r1;
      e.sd0 = (j < W) ? w0[W-1-j] : 1'b0;
      e.sd1 = (j < W) ? w1[W-1-j] : 1'b0;
      e.ur  = (i == 0) ? ur : 1'b0;
      exp_q.push_back(e);
    end
    for (int c = 0; c < 2 * s; c++) begin
      edge_drive((c < s) ? 1'b0 : 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (sd0 !== e.sd0 || sd1 !== e.sd1 || ur0 !== e.ur || ur1 !== e.ur) begin
        n_bad++;
        $display("FAIL %s cyc %0d: got sd=%b/%b ur=%b/%b want sd=%b/%b ur=%b",
                 tag, c, sd0, sd1, ur0, ur1, e.sd0, e.sd1, e.ur);
      end
    end
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    lrck = 1'b1;
    repeat (3) @(posedge bclk);
    @(negedge bclk);
    n_cmp++;
    if (sd0 !== 1'b0 || sd1 !== 1'b0 || ur0 !== 1'b0 || ur1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out: got sd=%b/%b ur=%b/%b want 0", sd0, sd1, ur0, ur1);
    end
    n_cmp++;
    if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b/%b want 1", ready0, ready1);
    end
    @(posedge bclk);
    #1 rst = 1'b0;
    @(negedge bclk);
    rdy_prev = ready0;
    exp_q.delete();
    idle("idle_hi", 3, 1'b1);
    send_frame("first_underrun", 16, '0, '0, '0, '0, 1'b1);
  endtask

  task automatic test_data;
    offer(16'hA5C3, 16'h0F81);
    idle("accept", 1, 1'b1);
    n_cmp++;
    if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
      n_bad++;
      $display("FAIL accept_ready: got %b/%b want 0", ready0, ready1);
    end
    idle("wait", 1, 1'b1);
    send_frame("a5c3_0f81", 16, 16'hA5C3, 16'h0F81, 16'hA5C3, 16'h0F81, 1'b0);
    n_cmp++;
    if (ready0 !== 1'b1) begin
      n_bad++;
      $display("FAIL data_ready_after: got %b want 1", ready0);
    end
  endtask

  task automatic test_back_to_back;
    offer(16'h8001, 16'h7FFE);
    idle("b2b_acc", 1, 1'b1);
    n_cmp++;
    if (ready0 !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ready_full: got %b want 0", ready0);
    end
    offer(16'hC0DE, 16'h3C5A);
    send_frame("b2b_x", 16, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE, 1'b0);
    n_cmp++;
    if (ready0 !== 1'b0 || tx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second_accept: got ready=%b valid=%b want 0/0",
               ready0, tx_valid);
    end
    send_frame("b2b_y", 16, 16'hC0DE, 16'h3C5A, 16'hC0DE, 16'h3C5A, 1'b0);
    n_cmp++;
    if (ready0 !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready_empty: got %b want 1", ready0);
    end
  endtask

  task automatic test_repeat;
    offer(16'h1234, 16'h5678);
    idle("rep_acc", 1, 1'b1);
    send_frame("rep_data", 16, 16'h1234, 16'h5678, 16'h1234, 16'h5678, 1'b0);
    send_frame("rep_underrun", 16, '0, '0, 16'h1234, 16'h5678, 1'b1);
  endtask

  task automatic test_slots;
    offer(16'hBEEF, 16'h4D2B);
    idle("long_acc", 1, 1'b1);
    send_frame("long_slot", 24, 16'hBEEF, 16'h4D2B, 16'hBEEF, 16'h4D2B, 1'b0);
    offer(16'h9A6F, 16'h5E31);
    idle("short_acc", 1, 1'b1);
    send_frame("short_slot", 12, 16'h9A6F, 16'h5E31, 16'h9A6F, 16'h5E31, 1'b0);
    send_frame("after_short", 16, '0, '0, 16'h9A6F, 16'h5E31, 1'b1);
  endtask

  task automatic test_mid_reset;
    exp_t e;
    logic [W-1:0] w;
    offer(16'hF00F, 16'h3CC3);
    idle("mr_acc", 2, 1'b1);
    w = 16'hF00F;
    exp_q.push_back('0);
    for (int i = 0; i < 8; i++) begin
      e.sd0 = w[W-1-i];
      e.sd1 = w[W-1-i];
      e.ur  = 1'b0;
      exp_q.push_back(e);
    end
    offer(16'h1357, 16'h2468);
    for (int c = 0; c < 9; c++) begin
      edge_drive(1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if (sd0 !== e.sd0 || sd1 !== e.sd1 || ur0 !== e.ur || ur1 !== e.ur) begin
        n_bad++;
        $display("FAIL mid_word cyc %0d: got sd=%b/%b ur=%b/%b want sd=%b ur=%b",
                 c, sd0, sd1, ur0, ur1, e.sd0, e.ur);
      end
    end
    n_cmp++;
    if (ready0 !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_pending: got ready=%b want 0", ready0);
    end
    rst = 1'b1;
    @(posedge bclk);
    #1 rst = 1'b0;
    @(negedge bclk);
    rdy_prev = ready0;
    n_cmp++;
    if (sd0 !== 1'b0 || sd1 !== 1'b0 || ready0 !== 1'b1 || ready1 !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset: got sd=%b/%b ready=%b/%b want sd=0 ready=1",
               sd0, sd1, ready0, ready1);
    end
    exp_q.delete();
    idle("post_rst_lo", 4, 1'b0);
    idle("post_rst_hi", 16, 1'b1);
    send_frame("resume", 16, '0, '0, '0, '0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_data();
    test_back_to_back();
    test_repeat();
    test_slots();
    test_mid_reset();
    idle("tail", 2, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
